switch_debouncer: RTL
=====================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter WIDTH, default 2, number of independent switch channels.
REQ-002 Parameter STABLE_CYCLES, default 500000, consecutive synchronized samples required to accept a new level; SHALL be >= 2.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 SW_in  input  WIDTH  raw asynchronous switch levels.
REQ-006 DB_out  output  WIDTH  debounced level per channel; drives the D input of the downstream gated D latch.
REQ-007 Rise  output  WIDTH  one-cycle pulse when DB_out goes 0->1; usable as the latch clock/enable.
REQ-008 Fall  output  WIDTH  one-cycle pulse when DB_out goes 1->0.

Function
REQ-009 Each channel SHALL pass SW_in through a two-flop synchronizer (sync1, sync2) before any other logic.
REQ-010 Each channel SHALL run a four-state FSM: IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW.
REQ-011 IDLE_LOW: sync2=1 -> CHK_HIGH with count=1; otherwise stay.
REQ-012 CHK_HIGH: sync2=0 -> IDLE_LOW, count cleared; sync2=1 and count=STABLE_CYCLES-1 -> IDLE_HIGH, DB_out=1, Rise=1; otherwise count+1.
REQ-013 IDLE_HIGH and CHK_LOW SHALL mirror REQ-011/012 with levels inverted, setting DB_out=0 and Fall=1 on acceptance.
REQ-014 Latency: new level first captured by sync1 on edge k and held stable -> DB_out changes on edge k+1+STABLE_CYCLES.
REQ-015 Any excursion shorter than STABLE_CYCLES consecutive sync2 samples SHALL leave DB_out, Rise, Fall unchanged.
REQ-016 Rise/Fall SHALL be high for exactly one cycle, in the same cycle DB_out first shows the new level; never both high on one channel.
REQ-017 Counter width SHALL be ceil(log2(STABLE_CYCLES+1)) bits; counter never wraps (saturates by construction via REQ-012).
REQ-018 Channels SHALL be fully independent; simultaneous transitions on multiple channels each follow REQ-014.

Reset
REQ-019 With Reset=1 at an edge: sync1, sync2, count, DB_out, Rise, Fall SHALL become 0 and state IDLE_LOW, overriding all other activity.
REQ-020 Reset mid-CHK_HIGH/CHK_LOW SHALL abort the check with no Rise/Fall pulse.
REQ-021 If SW_in is high when Reset deasserts, DB_out SHALL rise with a Rise pulse after the full REQ-014 latency, counted from the first post-reset edge.

Structure
REQ-022 Shared package debounce_pkg SHALL hold the FSM state enum and the counter-width function.
REQ-023 Per-channel logic SHALL live in sub-module debounce_channel (synchronizer, FSM, counter), instantiated WIDTH times by a generate loop in switch_debouncer.

Verification (bench uses WIDTH=2, STABLE_CYCLES=4)
REQ-024 Reset 2 cycles with SW_in=00 -> DB_out=00, Rise=00, Fall=00 from first edge with Reset=1.
REQ-025 SW_in[0] 0->1 captured at edge k, held -> DB_out[0]=1 and Rise[0]=1 after edge k+5, Rise[0]=0 after edge k+6, channel 1 unchanged.
REQ-026 SW_in[1] high for 3 cycles then low -> DB_out[1], Rise[1], Fall[1] stay 0 throughout.
REQ-027 SW_in[0] toggling every 2 cycles for 12 cycles, then held 1 -> exactly one Rise[0] pulse, 5 edges after final capture.
REQ-028 DB_out=11, SW_in 11->00 simultaneously -> DB_out=00 and Fall=11 on the same edge, 5 edges after capture.
REQ-029 Reset pulsed 1 cycle while channel 0 in CHK_HIGH, SW_in[0] held 1 -> no pulse during check; Rise[0] exactly 5 edges after first post-reset capture.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: per-channel FSM states and
// the helper that sizes the stability counter.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    CHK_HIGH  = 2'd1,
    IDLE_HIGH = 2'd2,
    CHK_LOW   = 2'd3
  } db_state_t;

  // Bits needed to hold values 0..stable_cycles inclusive.
  function automatic int count_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced switch channel: two-flop synchronizer feeding a four-state
// accept/reject FSM with a stability counter. DB_out-style level plus
// single-cycle rise/fall pulses, all registered.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = count_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = CW'(0);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;
  db_state_t     state;

  // Bring the asynchronous switch level into the clock domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: a new level is accepted only after STABLE_CYCLES
  // consecutive matching synchronized samples; the count is cleared on any
  // mismatch, so it can never exceed LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE_LOW;
      count <= ZERO;
      db    <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync2) begin
            state <= CHK_HIGH;
            count <= ONE;
          end else begin
            count <= ZERO;
          end
        end
        CHK_HIGH: begin
          if (!sync2) begin
            state <= IDLE_LOW;
            count <= ZERO;
          end else if (count == LAST) begin
            state <= IDLE_HIGH;
            count <= ZERO;
            db    <= 1'b1;
            rise  <= 1'b1;
          end else begin
            count <= count + ONE;
          end
        end
        IDLE_HIGH: begin
          if (!sync2) begin
            state <= CHK_LOW;
            count <= ONE;
          end else begin
            count <= ZERO;
          end
        end
        CHK_LOW: begin
          if (sync2) begin
            state <= IDLE_HIGH;
            count <= ZERO;
          end else if (count == LAST) begin
            state <= IDLE_LOW;
            count <= ZERO;
            db    <= 1'b0;
            fall  <= 1'b1;
          end else begin
            count <= count + ONE;
          end
        end
        default: begin
          state <= IDLE_LOW;
          count <= ZERO;
          db    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Multi-channel switch debouncer: WIDTH independent debounce channels.
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int STABLE_CYCLES = 500000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW_in,
  output logic [WIDTH-1:0] DB_out,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk  (Clk),
      .reset(Reset),
      .sw   (SW_in[i]),
      .db   (DB_out[i]),
      .rise (Rise[i]),
      .fall (Fall[i])
    );
  end

endmodule
